// File: rtl/mult8_seq_sched.sv
`default_nettype none
// ============================================================================
// Module  : mult8_seq_sched
// Purpose : 8x8 unsigned multiply scheduled over four cycles on an external
//           4x4 sub-multiplier. Optional self-check: MULT8_SELFCHECK_EN.
// Rev     : 1.0  initial release
// ============================================================================
module mult8_seq_sched #(
    parameter int SUB_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*SUB_W-1:0]   a,
    input  logic [2*SUB_W-1:0]   b,
    output logic [SUB_W-1:0]     mul_a,
    output logic [SUB_W-1:0]     mul_b,
    input  logic [2*SUB_W-1:0]   mul_p,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*SUB_W-1:0]   p,
    output logic                 err
);

    localparam int c_OP_W  = 2 * SUB_W;
    localparam int c_RES_W = 4 * SUB_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_k;
    logic [c_OP_W-1:0]   r_a;
    logic [c_OP_W-1:0]   r_b;
    logic [c_RES_W-1:0]  r_acc;
    logic [c_RES_W-1:0]  r_p;
    logic [c_RES_W-1:0]  w_shifted;
    logic [c_RES_W-1:0]  w_acc_next;
    logic                w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        mul_a        = '0;
        mul_b        = '0;
        case (r_state)
            S_IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                // k[1] picks the multiplicand nibble, k[0] the multiplier nibble
                mul_a = r_k[1] ? r_a[c_OP_W-1:SUB_W] : r_a[SUB_W-1:0];
                mul_b = r_k[0] ? r_b[c_OP_W-1:SUB_W] : r_b[SUB_W-1:0];
                if (r_k == 2'd3) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
                if (out_ready) begin
                    w_state_next = in_valid ? S_MUL : S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_shifted = '0;
        case (r_k)
            2'd0:    w_shifted = {{c_OP_W{1'b0}}, mul_p};
            2'd1,
            2'd2:    w_shifted = {{SUB_W{1'b0}}, mul_p, {SUB_W{1'b0}}};
            default: w_shifted = {mul_p, {c_OP_W{1'b0}}};
        endcase
    end

    assign w_acc_next = r_acc + w_shifted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k   <= 2'd0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_p   <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
            r_k   <= 2'd0;
        end else if (r_state == S_MUL) begin
            r_acc <= w_acc_next;
            r_k   <= r_k + 2'd1;
            // p only moves on DONE entry so it stays stable while unread
            if (r_k == 2'd3) begin
                r_p <= w_acc_next;
            end
        end
    end

    assign p = r_p;

`ifdef MULT8_SELFCHECK_EN
    logic                r_err;
    logic [c_RES_W-1:0]  w_ref;

    assign w_ref = {{c_OP_W{1'b0}}, r_a} * {{c_OP_W{1'b0}}, r_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((r_state == S_MUL) && (r_k == 2'd3) && (w_acc_next != w_ref)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult8_seq_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_mult8_seq_sched
// Purpose : Directed self-checking bench for mult8_seq_sched with a
//           behavioural 4x4 sub-multiplier (optionally faulty).
// Rev     : 1.0  initial release
// ============================================================================
module tb_mult8_seq_sched;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] p;
    logic        err;
    logic        fault_en;

    int checks   = 0;
    int failures = 0;

`ifdef MULT8_SELFCHECK_EN
    localparam logic c_EXP_ERR = 1'b1;
`else
    localparam logic c_EXP_ERR = 1'b0;
`endif

    mult8_seq_sched #(.SUB_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .err       (err)
    );

    assign mul_p = fault_en ? (({4'b0, mul_a} * {4'b0, mul_b}) | 8'h01)
                            :  ({4'b0, mul_a} * {4'b0, mul_b});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept one pair, then count edges until out_valid; consume the result.
    task automatic do_mult(input logic [7:0] ta, input logic [7:0] tb_v,
                           input logic [15:0] exp_p, input string name);
        int cyc;
        a = ta; b = tb_v; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1 || cyc !== 4) begin
            failures++;
            $display("FAIL %s_latency: out_valid=%b cycles=%0d required 1 / 4", name, out_valid, cyc);
        end
        checks++;
        if (p !== exp_p) begin
            failures++;
            $display("FAIL %s_p: got %h required %h", name, p, exp_p);
        end
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; fault_en = 1'b0;
        tick; tick;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || p !== 16'h0 || err !== 1'b0
            || mul_a !== 4'h0 || mul_b !== 4'h0) begin
            failures++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b p=%h err=%b mul=%h/%h required 0 0 0000 0 0/0",
                     in_ready, out_valid, p, err, mul_a, mul_b);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        tick;
    endtask

    task automatic test_schedule;
        logic [3:0] exp_a [4];
        logic [3:0] exp_b [4];
        exp_a[0] = 4'd2; exp_b[0] = 4'd4;
        exp_a[1] = 4'd2; exp_b[1] = 4'd3;
        exp_a[2] = 4'd1; exp_b[2] = 4'd4;
        exp_a[3] = 4'd1; exp_b[3] = 4'd3;
        a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sched_in_ready: got %b required 1", in_ready);
        end
        tick;
        in_valid = 1'b0; a = 8'hEE; b = 8'hEE;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mul_a !== exp_a[k] || mul_b !== exp_b[k] || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL sched_step%0d: mul=(%0d,%0d) ov=%b ir=%b required (%0d,%0d) 0 0",
                         k, mul_a, mul_b, out_valid, in_ready, exp_a[k], exp_b[k]);
            end
            tick;
        end
        checks++;
        if (out_valid !== 1'b1 || p !== 16'h03A8 || mul_a !== 4'h0 || mul_b !== 4'h0) begin
            failures++;
            $display("FAIL sched_result: ov=%b p=%h mul=%h/%h required 1 03a8 0/0", out_valid, p, mul_a, mul_b);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL sched_idle: ov=%b ir=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_corners;
        do_mult(8'hFF, 8'hFF, 16'hFE01, "max");
        do_mult(8'hA5, 8'h00, 16'h0000, "zero");
        do_mult(8'h00, 8'h9C, 16'h0000, "zero_a");
    endtask

    task automatic test_backpressure;
        int cyc;
        a = 8'h0B; b = 8'h0D; in_valid = 1'b1; out_ready = 1'b0;
        tick;
        a = 8'h55; b = 8'h55;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || p !== 16'h008F || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: ov=%b p=%h ir=%b required 1 008f 0", i, out_valid, p, in_ready);
            end
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: ir=%b ov=%b required 1 1", in_ready, out_valid);
        end
        tick;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_taken: ov=%b required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        int t1;
        a = 8'h0F; b = 8'h0F; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        a = 8'h80; b = 8'h02;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        t1 = cyc;
        checks++;
        if (out_valid !== 1'b1 || p !== 16'h00E1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: ov=%b p=%h ir=%b required 1 00e1 1", out_valid, p, in_ready);
        end
        tick;
        cyc++;
        in_valid = 1'b0;
        while (!out_valid && cyc < 40) begin
            tick;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1 || p !== 16'h0100 || (cyc - t1) !== 5) begin
            failures++;
            $display("FAIL b2b_second: ov=%b p=%h spacing=%0d required 1 0100 5", out_valid, p, cyc - t1);
        end
        tick;
    endtask

    task automatic test_reset_abort;
        logic seen;
        a = 8'h77; b = 8'h11; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) seen = 1'b1;
            tick;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_valid: out_valid seen=%b required 0", seen);
        end
        do_mult(8'h03, 8'h05, 16'h000F, "after_abort");
    endtask

    task automatic test_selfcheck;
        int cyc;
        fault_en = 1'b1;
        a = 8'h02; b = 8'h02; in_valid = 1'b1; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick;
            cyc++;
        end
        checks++;
        if (out_valid !== 1'b1 || err !== c_EXP_ERR) begin
            failures++;
            $display("FAIL selfcheck_err: ov=%b err=%b required 1 %b", out_valid, err, c_EXP_ERR);
        end
        fault_en = 1'b0;
        tick; tick; tick;
        checks++;
        if (err !== c_EXP_ERR) begin
            failures++;
            $display("FAIL selfcheck_sticky: err=%b required %b", err, c_EXP_ERR);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL selfcheck_clear: err=%b required 0", err);
        end
    endtask

    initial begin
        test_reset;
        test_schedule;
        test_corners;
        test_backpressure;
        test_back_to_back;
        test_reset_abort;
        test_selfcheck;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult8_seq_sched.md
# mult8_seq_sched

Sequential 8x8 unsigned multiplier scheduler that reuses one external 4x4 combinational sub-multiplier over four cycles. It accepts operand pairs on a valid/ready handshake and drives the sub-multiplier's operand ports with one nibble pair per cycle. It then accumulates the returned 8-bit partial products into a 16-bit result, presented on a valid/ready output. It sits directly upstream and downstream of the team's generated 4-bit multipliers, so any variant can be dropped in unchanged.

## Interface
- SUB_W, 4, sub-multiplier operand width; only 4 is supported, and output width is 4*SUB_W.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  8  multiplicand, unsigned.
- b  in  8  multiplier, unsigned.
- mul_a  out  4  operand A to the external 4x4 multiplier.
- mul_b  out  4  operand B to the external 4x4 multiplier.
- mul_p  in  8  product from the external 4x4 multiplier; combinational in mul_a/mul_b, same cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- p  out  16  product a*b.
- err  out  1  sticky self-check failure (see Configuration).

## Operation
- States:
  - IDLE: in_ready=1.
  - MUL: step counter k=0..3.
  - DONE: out_valid=1.
- Accept: at an edge with in_valid && in_ready:
  - register a and b;
  - clear acc to 0;
  - set k=0;
  - go to MUL.
- Step schedule (mul_a, mul_b, shift):
  - k=0: (a[3:0], b[3:0]), <<0
  - k=1: (a[3:0], b[7:4]), <<4
  - k=2: (a[7:4], b[3:0]), <<4
  - k=3: (a[7:4], b[7:4]), <<8
- In MUL, each edge updates acc <= acc + (mul_p << shift), using 16-bit arithmetic with no overflow possible.
  - After k=3 the next state is DONE, and p = final acc.
- DONE holds p and out_valid until out_valid && out_ready.
  - in_ready = 1 in DONE when out_ready=1, so a new pair can be accepted on the same edge the result is taken.
  - If a new pair is accepted, the next state is MUL; otherwise it is IDLE.
- mul_a and mul_b are 0 in IDLE and DONE.
- p is only meaningful while out_valid=1; it holds its last value otherwise.
- Operands are captured at accept. Changes on a/b after accept are ignored.
- in_valid while busy (MUL, or DONE with out_ready=0) is not accepted, and the upstream holds.

## Timing
- Reset (rst high at an edge), all values in effect from the next cycle:
  - state IDLE, k=0, acc=0, p=0, out_valid=0, err=0, mul_a=mul_b=0;
  - in_ready=0 while rst is high and 1 in the first cycle after.
- Latency: accept at edge E0, accumulations at edges E1..E4, out_valid=1 from the cycle after E4. That is 4 cycles from accept to result.
- Throughput: one result per 5 cycles with out_ready held high (accept at the DONE-exit edge).
- Reset mid-operation aborts the product. No out_valid is issued for the aborted pair.
- Handshake rule: out_valid never drops and p never changes until the result is accepted.

## Configuration
- MULT8_SELFCHECK_EN defined:
  - on the DONE-entry edge, compare the final acc against a behavioural a*b of the registered operands;
  - on mismatch set err=1;
  - err stays set until rst.
- MULT8_SELFCHECK_EN undefined: err is tied to 0 and no comparator is synthesised.

## Test plan
- Reset, then a=0x12, b=0x34, out_ready=1:
  - mul_a/mul_b sequence is (2,4), (2,3), (1,4), (1,3);
  - out_valid occurs 4 cycles after accept with p=0x03A8.
- a=0xFF, b=0xFF -> p=0xFE01. a=0xA5, b=0x00 -> p=0x0000.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid.
  - p and out_valid stay stable; in_ready=0 throughout.
  - Raising out_ready completes the transfer.
- Back-to-back: keep in_valid=1 with pairs (0x0F,0x0F), (0x80,0x02), with out_ready=1.
  - Results are 0x00E1 and then 0x0100, exactly 5 cycles apart.
- Reset pulse at k=2: no out_valid for the aborted pair; the next pair 0x03*0x05 gives p=0x000F.
- With MULT8_SELFCHECK_EN, a faulty sub-multiplier model that forces mul_p[0]=1 gives:
  - 0x02*0x02 -> err=1 after DONE entry, held until reset;
  - without the macro, err=0.
